// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
package riscv_ctrl_pkg;

    localparam int unsigned INSTRET_W = 32;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LINKWB,
        S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_DIRECT = 2'b10;

endpackage

// File: rtl/branch_resolve.sv
// Branch condition evaluation from funct3 and the ALU compare flags.
module branch_resolve (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:         taken = zero;
            3'b001:         taken = !zero;
            3'b100, 3'b110: taken = lt;
            3'b101, 3'b111: taken = !lt;
            default:        taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I datapath, with retired-instruction counter.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           result_src,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    state_t state;
    state_t next_state;
    logic   taken;

    branch_resolve u_branch_resolve (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .taken  (taken)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // An instruction retires when control returns to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instret <= '0;
        else if (state != S_FETCH && next_state == S_FETCH)
            instret <= instret + INSTRET_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       illegal <= 1'b0;
        else if (next_state == S_ILLEGAL) illegal <= 1'b1;
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;

        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_DIRECT;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_ALUWB;
                    default:           next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_IMM;
                next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a  = SRCA_REG;
                alu_op     = ALUOP_R;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_I;
                next_state = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a  = SRCA_ZERO;
                alu_src_b  = SRCB_IMM;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_REG;
                alu_op     = ALUOP_BR;
                pc_write   = taken;
                next_state = S_FETCH;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                next_state = S_LINKWB;
            end
            S_JALR: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_IMM;
                result_src = RES_DIRECT;
                pc_write   = 1'b1;
                next_state = S_LINKWB;
            end
            S_LINKWB: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_DIRECT;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_ILLEGAL: next_state = S_ILLEGAL;
            default:   next_state = S_ILLEGAL;
        endcase

        // No strobe may escape while reset is held, even mid-stall.
        if (reset) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors and instret checks.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero;
    logic        lt;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic        illegal;
    logic [31:0] instret;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .lt         (lt),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .illegal    (illegal),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    // Field order: req wr adr ir pc rw | a b op rs | ill
    function automatic logic [14:0] ov(input logic req, input logic wr, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic [1:0] rs,
                                       input logic ill);
        return {req, wr, adr, irw, pcw, rw, a, b, op, rs, ill};
    endfunction

    logic [14:0] obs;
    assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, alu_op, result_src, illegal};

    logic [14:0] V_RESET, V_FETCH_GO, V_FETCH_STALL, V_DECODE, V_EXECI, V_ALUWB,
                 V_MEMADR, V_MEMREAD, V_MEMWB, V_MEMWRITE, V_BR_NT, V_BR_T,
                 V_JALR, V_LINKWB, V_ILLEGAL;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_v(input string tag, input logic [14:0] exp);
        #1;
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s outputs obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input logic [31:0] exp);
        checks++;
        assert (instret === exp) else begin
            failures++;
            $error("FAIL %s instret obs=%0d exp=%0d", tag, instret, exp);
        end
    endtask

    initial begin
        V_RESET       = ov(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0);
        V_FETCH_GO    = ov(1,0,0,1,1,0, 2'b00,2'b10,2'b00,2'b10, 0);
        V_FETCH_STALL = ov(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0);
        V_DECODE      = ov(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0);
        V_EXECI       = ov(0,0,0,0,0,0, 2'b10,2'b01,2'b11,2'b00, 0);
        V_ALUWB       = ov(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0);
        V_MEMADR      = ov(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0);
        V_MEMREAD     = ov(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0);
        V_MEMWB       = ov(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 0);
        V_MEMWRITE    = ov(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0);
        V_BR_NT       = ov(0,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 0);
        V_BR_T        = ov(0,0,0,0,1,0, 2'b10,2'b00,2'b01,2'b00, 0);
        V_JALR        = ov(0,0,0,0,1,0, 2'b10,2'b01,2'b00,2'b10, 0);
        V_LINKWB      = ov(0,0,0,0,0,1, 2'b01,2'b10,2'b00,2'b10, 0);
        V_ILLEGAL     = ov(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1);

        // Reset held during FETCH with mem_ready high: no strobes.
        reset = 1'b1; mem_ready = 1'b1; opcode = 7'b0010011; funct3 = 3'b000;
        zero = 1'b0; lt = 1'b0;
        #1;
        chk_v("reset_outs", V_RESET);
        chk_n("reset_instret", 32'd0);
        cyc();
        chk_v("reset_held_edge", V_RESET);

        // ADDI, zero-wait memory: 4 cycles.
        cyc(); reset = 1'b0;
        chk_v("addi_fetch", V_FETCH_GO);
        chk_n("addi_start", 32'd0);
        cyc(); chk_v("addi_decode", V_DECODE);
        cyc(); chk_v("addi_execi", V_EXECI);
        cyc(); chk_v("addi_aluwb", V_ALUWB);
        chk_n("addi_before_retire", 32'd0);

        // LW with two stall cycles in FETCH and in MEMREAD: 9 cycles.
        cyc(); opcode = 7'b0000011; mem_ready = 1'b0;
        chk_v("lw_fetch_stall0", V_FETCH_STALL);
        chk_n("addi_retired", 32'd1);
        cyc(); chk_v("lw_fetch_stall1", V_FETCH_STALL);
        cyc(); mem_ready = 1'b1; chk_v("lw_fetch_go", V_FETCH_GO);
        cyc(); chk_v("lw_decode", V_DECODE);
        cyc(); chk_v("lw_memadr", V_MEMADR);
        cyc(); mem_ready = 1'b0; chk_v("lw_memread_stall0", V_MEMREAD);
        cyc(); chk_v("lw_memread_stall1", V_MEMREAD);
        cyc(); mem_ready = 1'b1; chk_v("lw_memread_go", V_MEMREAD);
        cyc(); mem_ready = 1'b0; chk_v("lw_memwb", V_MEMWB);
        chk_n("lw_before_retire", 32'd1);

        // BNE with zero=1 (not taken): 3 cycles.
        cyc(); opcode = 7'b1100011; funct3 = 3'b001; zero = 1'b1; mem_ready = 1'b1;
        chk_v("bne0_fetch", V_FETCH_GO);
        chk_n("lw_retired", 32'd2);
        cyc(); chk_v("bne0_decode", V_DECODE);
        cyc(); chk_v("bne0_branch", V_BR_NT);

        // BNE with zero=0 (taken).
        cyc(); zero = 1'b0;
        chk_v("bne1_fetch", V_FETCH_GO);
        chk_n("bne0_retired", 32'd3);
        cyc(); chk_v("bne1_decode", V_DECODE);
        cyc(); chk_v("bne1_branch", V_BR_T);

        // JALR then link writeback.
        cyc(); opcode = 7'b1100111; funct3 = 3'b000;
        chk_v("jalr_fetch", V_FETCH_GO);
        chk_n("bne1_retired", 32'd4);
        cyc(); chk_v("jalr_decode", V_DECODE);
        cyc(); chk_v("jalr_jalr", V_JALR);
        cyc(); chk_v("jalr_linkwb", V_LINKWB);

        // AUIPC: 3 cycles.
        cyc(); opcode = 7'b0010111;
        chk_v("auipc_fetch", V_FETCH_GO);
        chk_n("jalr_retired", 32'd5);
        cyc(); chk_v("auipc_decode", V_DECODE);
        cyc(); chk_v("auipc_aluwb", V_ALUWB);

        // SW stalled 3 cycles, then aborted by reset.
        cyc(); opcode = 7'b0100011;
        chk_v("sw_fetch", V_FETCH_GO);
        chk_n("auipc_retired", 32'd6);
        cyc(); chk_v("sw_decode", V_DECODE);
        cyc(); mem_ready = 1'b0; chk_v("sw_memadr", V_MEMADR);
        for (int i = 0; i < 3; i++) begin
            cyc(); chk_v("sw_memwrite_stall", V_MEMWRITE);
            chk_n("sw_stall_instret", 32'd6);
        end
        cyc(); mem_ready = 1'b1; reset = 1'b1;
        chk_v("sw_reset_abort", V_RESET);
        chk_n("sw_reset_instret", 32'd0);
        cyc(); chk_v("sw_reset_held", V_RESET);
        chk_n("sw_no_retire", 32'd0);

        // Unsupported opcode: sticky illegal, no strobes.
        cyc(); reset = 1'b0; opcode = 7'b0000000;
        chk_v("ill_fetch", V_FETCH_GO);
        cyc(); chk_v("ill_decode", V_DECODE);
        for (int i = 0; i < 20; i++) begin
            cyc(); mem_ready = i[0]; opcode = 7'b0010011;
            chk_v("ill_hold", V_ILLEGAL);
        end
        chk_n("ill_instret", 32'd0);

        // Reserved branch funct3 also traps.
        reset = 1'b1; #1;
        chk_v("ill_reset_clears", V_RESET);
        cyc(); reset = 1'b0; mem_ready = 1'b1; opcode = 7'b1100011; funct3 = 3'b010;
        chk_v("brill_fetch", V_FETCH_GO);
        cyc(); chk_v("brill_decode", V_DECODE);
        cyc(); chk_v("brill_illegal", V_ILLEGAL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
